// File: rtl/top_if_if.sv
// Fetch-stage bus bundle: debug-unit memory load, decode feedback and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is its surroundings.
interface top_if_if #(
    parameter int unsigned LENGTH_INSTRUCTION = 32,
    parameter int unsigned CANT_BITS_ADDR     = 11,
    parameter int unsigned CANT_BITS_CONTADOR = 32
) ();
    logic                          i_start;
    logic                          i_wr_enable_mem;
    logic [CANT_BITS_ADDR-1:0]     i_wr_addr_mem;
    logic [LENGTH_INSTRUCTION-1:0] i_wr_data_mem;
    logic [CANT_BITS_ADDR-1:0]     i_branch_dir;
    logic                          i_branch_control;
    logic                          i_stall;
    logic                          i_enable_pipeline;
    logic                          i_enable_etapa;
    logic [LENGTH_INSTRUCTION-1:0] o_instruction;
    logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc;
    logic [CANT_BITS_ADDR-1:0]     o_pc;
    logic                          o_halt_detected;
    logic [1:0]                    o_state;
    logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos;

    modport slave (
        input  i_start, i_wr_enable_mem, i_wr_addr_mem, i_wr_data_mem,
               i_branch_dir, i_branch_control, i_stall, i_enable_pipeline, i_enable_etapa,
        output o_instruction, o_out_adder_pc, o_pc, o_halt_detected, o_state, o_contador_ciclos
    );

    modport master (
        output i_start, i_wr_enable_mem, i_wr_addr_mem, i_wr_data_mem,
               i_branch_dir, i_branch_control, i_stall, i_enable_pipeline, i_enable_etapa,
        input  o_instruction, o_out_adder_pc, o_pc, o_halt_detected, o_state, o_contador_ciclos
    );
endinterface

// File: rtl/top_if.sv
// MIPS instruction-fetch stage: PC, debug-loaded instruction memory and IF/ID register,
// with LOAD / RUN / HALTED sequencing, hazard stall, branch redirect and halt freeze.
module top_if #(
    parameter int unsigned LENGTH_INSTRUCTION = 32,
    parameter int unsigned CANT_BITS_ADDR     = 11,
    parameter int unsigned RAM_DEPTH          = 2048,
    parameter logic [31:0] HALT_INSTRUCTION   = 32'hFFFFFFFF,
    parameter int unsigned CANT_BITS_CONTADOR = 32
) (
    input  logic   i_clock,
    input  logic   i_soft_reset,
    top_if_if.slave bus
);
    localparam int unsigned INSTR_W = LENGTH_INSTRUCTION;
    localparam int unsigned ADDR_W  = CANT_BITS_ADDR;
    localparam int unsigned CNT_W   = CANT_BITS_CONTADOR;
    localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_INSTRUCTION);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc;
    logic [INSTR_W-1:0]  instruction;
    logic [ADDR_W-1:0]   adder_pc;
    logic [CNT_W-1:0]    contador;
    logic [INSTR_W-1:0]  mem [RAM_DEPTH];

    logic                advance_c;
    logic                load_c;
    logic [ADDR_W-1:0]   pc_next_c;
    logic [ADDR_W-1:0]   fetch_addr_c;
    logic [INSTR_W-1:0]  fetch_word_c;

    // Stall and disabled enables are indistinguishable: both simply block advance.
    assign advance_c    = (state == ST_RUN) & bus.i_enable_pipeline & bus.i_enable_etapa & ~bus.i_stall;
    assign pc_next_c    = bus.i_branch_control ? bus.i_branch_dir : pc + ADDR_W'(1);
    assign fetch_addr_c = (state == ST_LOAD) ? '0 : pc_next_c;
    assign fetch_word_c = mem[fetch_addr_c];

    // Debug-unit load port, only open while in LOAD; contents survive reset.
    always_ff @(posedge i_clock) begin
        if (bus.i_wr_enable_mem && (state == ST_LOAD)) begin
            mem[bus.i_wr_addr_mem] <= bus.i_wr_data_mem;
        end
    end

    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        case (state)
            ST_LOAD: begin
                if (bus.i_start) begin
                    load_c     = 1'b1;
                    state_next = (fetch_word_c == HALT_WORD) ? ST_HALTED : ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance_c) begin
                    load_c = 1'b1;
                    if (fetch_word_c == HALT_WORD) begin
                        state_next = ST_HALTED;
                    end
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // PC and IF/ID register; the start load primes address 0 without counting a cycle.
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state       <= ST_LOAD;
            pc          <= '0;
            instruction <= '0;
            adder_pc    <= '0;
            contador    <= '0;
        end else begin
            state <= state_next;
            if (load_c) begin
                pc          <= fetch_addr_c;
                instruction <= fetch_word_c;
                adder_pc    <= fetch_addr_c + ADDR_W'(1);
                if (state == ST_RUN) begin
                    contador <= contador + CNT_W'(1);
                end
            end
        end
    end

    assign bus.o_instruction     = instruction;
    assign bus.o_out_adder_pc    = adder_pc;
    assign bus.o_pc              = pc;
    assign bus.o_halt_detected   = (state == ST_HALTED);
    assign bus.o_state           = state;
    assign bus.o_contador_ciclos = contador;
endmodule
